// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: one valid/ready bus transaction per access, pipeline stall, load alignment.
// Optional misaligned-access trap is enabled by defining LSU_MISALIGN_TRAP_EN.
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        BusErrM,
  output logic        MisalignM,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        mis_q, mis_d;
  logic        valid_q, valid_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic        access;
  logic        trap;
  logic [1:0]  off;

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] o,
                                               input logic [31:0] w);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    shifted = w >> {o, 3'b000};
    b = shifted[7:0];
    h = o[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'd0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] o);
    case (f3[1:0])
      2'b00:   return 4'b0001 << o;
      2'b01:   return 4'b0011 << {o[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] o);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return o[0];
      default: return o != 2'b00;
    endcase
  endfunction
`endif

  assign access = MemReadM | MemWriteM;
  assign off    = ALUResultM[1:0];

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = is_misaligned(Funct3M, off);
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    mis_d   = 1'b0;
    valid_d = valid_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (access) begin
          if (trap) begin
            state_d = S_DONE;
            rdata_d = 32'd0;
            mis_d   = 1'b1;
          end else begin
            state_d = S_REQ;
            valid_d = 1'b1;
            addr_d  = {ALUResultM[31:2], 2'b00};
            we_d    = MemWriteM;
            wstrb_d = MemWriteM ? store_strobe(Funct3M, off) : 4'b1111;
            wdata_d = MemWriteM ? store_data(Funct3M, WriteDataM) : 32'd0;
          end
        end
      end
      S_REQ: begin
        // No timeout here: the bus may hold off acceptance indefinitely.
        if (bus_req_ready) begin
          valid_d = 1'b0;
          cnt_d   = 16'd0;
          state_d = we_q ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus_rsp_valid) begin
          rdata_d = load_extract(Funct3M, off, bus_rdata);
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = 32'd0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
      valid_q <= 1'b0;
      addr_q  <= 32'd0;
      we_q    <= 1'b0;
      wstrb_q <= 4'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
    end
  end

  // Stall is gated by reset so the pipeline is released as soon as reset is seen.
  assign StallM = !reset & (((state_q == S_IDLE) & access) | (state_q == S_REQ) |
                            (state_q == S_WAIT));

  assign ReadDataM     = rdata_q;
  assign BusErrM       = err_q;
  assign MisalignM     = mis_q;
  assign bus_req_valid = valid_q;
  assign bus_addr      = addr_q;
  assign bus_we        = we_q;
  assign bus_wstrb     = wstrb_q;
  assign bus_wdata     = wdata_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: expected bus requests and DONE results are queued at issue
// and popped by independent monitors. Honors LSU_MISALIGN_TRAP_EN for the misaligned vectors.
module tb_mem_stage_lsu;

  logic        clk, reset;
  logic        MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM, ReadDataM;
  logic        StallM, BusErrM, MisalignM;
  logic        bus_req_valid, bus_req_ready, bus_we, bus_rsp_valid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;

  mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM), .StallM(StallM),
    .BusErrM(BusErrM), .MisalignM(MisalignM), .bus_req_valid(bus_req_valid),
    .bus_req_ready(bus_req_ready), .bus_addr(bus_addr), .bus_we(bus_we), .bus_wstrb(bus_wstrb),
    .bus_wdata(bus_wdata), .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic        mis;
  } rsp_exp_t;

  bus_exp_t bus_q[$];
  rsp_exp_t rsp_q[$];

  int checks = 0;
  int errors = 0;

  int          cfg_rdly = 0;
  int          cfg_sdly = 0;
  logic [31:0] cfg_rdata = 32'd0;
  bit          late_rsp = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Bus responder: ready after cfg_rdly REQ cycles, response in WAIT cycle cfg_sdly (-1 = never).
  initial begin : responder
    int  req_cnt;
    int  wait_cnt;
    bit  in_wait;
    req_cnt = 0; wait_cnt = 0; in_wait = 0;
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = 32'd0;
    forever begin
      @(posedge clk); #2;
      bus_rsp_valid = late_rsp;
      if (late_rsp) bus_rdata = 32'h5A5A5A5A;
      if (reset || !StallM) begin
        in_wait = 0;
      end else if (in_wait) begin
        if (wait_cnt == cfg_sdly) begin
          bus_rsp_valid = 1'b1;
          bus_rdata = cfg_rdata;
          in_wait = 0;
        end
        wait_cnt++;
      end
      if (bus_req_valid && !reset) begin
        bus_req_ready = (req_cnt >= cfg_rdly);
        req_cnt++;
        if (bus_req_ready && !bus_we) begin
          in_wait = 1;
          wait_cnt = 0;
        end
      end else begin
        bus_req_ready = 1'b0;
        req_cnt = 0;
      end
    end
  end

  // Bus monitor: field stability while waiting for ready, and request contents at the handshake.
  initial begin : bus_monitor
    bit       prev_vld;
    bus_exp_t prev, e;
    prev_vld = 0;
    forever begin
      @(negedge clk);
      if (!reset && bus_req_valid) begin
        if (prev_vld) begin
          checks++;
          if (bus_addr !== prev.addr || bus_we !== prev.we || bus_wstrb !== prev.wstrb ||
              bus_wdata !== prev.wdata) begin
            errors++;
            $display("FAIL bus_stable: got %08h/%0b/%04b/%08h expected %08h/%0b/%04b/%08h",
                     bus_addr, bus_we, bus_wstrb, bus_wdata, prev.addr, prev.we, prev.wstrb,
                     prev.wdata);
          end
        end
        if (bus_req_ready) begin
          prev_vld = 0;
          if (bus_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL bus_unexpected: got request addr 0x%08h expected no request", bus_addr);
          end else begin
            e = bus_q.pop_front();
            chk("bus_addr", bus_addr, e.addr);
            chk("bus_we", {31'd0, bus_we}, {31'd0, e.we});
            chk("bus_wstrb", {28'd0, bus_wstrb}, {28'd0, e.wstrb});
            if (e.we) chk("bus_wdata", bus_wdata, e.wdata);
          end
        end else begin
          prev_vld = 1;
          prev.addr = bus_addr; prev.we = bus_we; prev.wstrb = bus_wstrb; prev.wdata = bus_wdata;
        end
      end else begin
        prev_vld = 0;
      end
    end
  end

  // Result monitor: DONE is the cycle an access is presented with StallM low.
  initial begin : rsp_monitor
    rsp_exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && (MemReadM || MemWriteM) && !StallM) begin
        if (rsp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected: got DONE expected none");
        end else begin
          e = rsp_q.pop_front();
          chk("ReadDataM", ReadDataM, e.rd);
          chk("BusErrM", {31'd0, BusErrM}, {31'd0, e.err});
          chk("MisalignM", {31'd0, MisalignM}, {31'd0, e.mis});
        end
      end else begin
        chk("pulse_idle", {30'd0, BusErrM, MisalignM}, 32'd0);
      end
    end
  end

  task automatic do_access(input string name, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                           input int rdly, input int sdly, input logic [31:0] rdata,
                           input int exp_stall, input logic exp_bus, input logic [3:0] exp_strb,
                           input logic [31:0] exp_wdata, input logic [31:0] exp_rd,
                           input logic exp_err, input logic exp_mis);
    bus_exp_t be;
    rsp_exp_t re;
    int       st;
    bit       done_seen;
    if (exp_bus) begin
      be.addr = {addr[31:2], 2'b00}; be.we = wr; be.wstrb = exp_strb; be.wdata = exp_wdata;
      bus_q.push_back(be);
    end
    re.rd = exp_rd; re.err = exp_err; re.mis = exp_mis;
    rsp_q.push_back(re);
    cfg_rdly = rdly; cfg_sdly = sdly; cfg_rdata = rdata;
    @(posedge clk); #1;
    MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = addr; WriteDataM = wd;
    st = 0; done_seen = 0;
    for (int i = 0; i < 200 && !done_seen; i++) begin
      @(negedge clk);
      if (StallM) st++;
      else done_seen = 1;
    end
    checks++;
    if (!done_seen) begin
      errors++;
      $display("FAIL %s_done: got no DONE within 200 cycles expected DONE", name);
    end else if (st != exp_stall) begin
      errors++;
      $display("FAIL %s_stall: got %0d stall cycles expected %0d", name, st, exp_stall);
    end
    @(posedge clk); #1;
    MemReadM = 1'b0; MemWriteM = 1'b0;
    chk({name, "_busq"}, bus_q.size(), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got simulation still running expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    reset = 1'b1; MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'b000;
    ALUResultM = 32'd0; WriteDataM = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ReadDataM", ReadDataM, 32'd0);
    chk("rst_StallM", {31'd0, StallM}, 32'd0);
    chk("rst_BusErrM", {31'd0, BusErrM}, 32'd0);
    chk("rst_MisalignM", {31'd0, MisalignM}, 32'd0);
    chk("rst_valid", {31'd0, bus_req_valid}, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_we", {31'd0, bus_we}, 32'd0);
    chk("rst_wstrb", {28'd0, bus_wstrb}, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    reset = 1'b0;

    do_access("lw",   1, 0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 3, 1, 4'hF, 32'h0,
              32'hDEADBEEF, 0, 0);
    do_access("lb",   1, 0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80FF0000, 3, 1, 4'hF, 32'h0,
              32'hFFFFFF80, 0, 0);
    do_access("lbu",  1, 0, 3'b100, 32'h103, 32'h0, 0, 0, 32'h80FF0000, 3, 1, 4'hF, 32'h0,
              32'h00000080, 0, 0);
    do_access("sb",   0, 1, 3'b000, 32'h202, 32'h12345678, 3, 0, 32'h0, 5, 1, 4'b0100,
              32'h78787878, 32'h00000080, 0, 0);
    do_access("lh",   1, 0, 3'b001, 32'h102, 32'h0, 0, 2, 32'h80011234, 5, 1, 4'hF, 32'h0,
              32'hFFFF8001, 0, 0);
    do_access("sh",   0, 1, 3'b001, 32'h206, 32'h0000BEEF, 0, 0, 32'h0, 2, 1, 4'b1100,
              32'hBEEFBEEF, 32'hFFFF8001, 0, 0);
    do_access("lbu1", 1, 0, 3'b100, 32'h101, 32'h0, 0, 0, 32'h0000A500, 3, 1, 4'hF, 32'h0,
              32'h000000A5, 0, 0);
    do_access("lw011", 1, 0, 3'b011, 32'h104, 32'h0, 0, 0, 32'h11223344, 3, 1, 4'hF, 32'h0,
              32'h11223344, 0, 0);
    do_access("tmo",  1, 0, 3'b010, 32'h300, 32'h0, 0, -1, 32'h0, 6, 1, 4'hF, 32'h0,
              32'h0, 1, 0);

    late_rsp = 1'b1;
    @(posedge clk); #1;
    late_rsp = 1'b0;
    @(negedge clk);
    chk("late_ReadDataM", ReadDataM, 32'd0);
    chk("late_StallM", {31'd0, StallM}, 32'd0);

    begin : reset_in_wait
      bus_exp_t be;
      be.addr = 32'h400; be.we = 1'b0; be.wstrb = 4'hF; be.wdata = 32'h0;
      bus_q.push_back(be);
      cfg_rdly = 0; cfg_sdly = -1;
      @(posedge clk); #1;
      MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h400;
      @(posedge clk); #1;
      @(posedge clk); #3;
      reset = 1'b1;
      #1;
      chk("rstw_valid", {31'd0, bus_req_valid}, 32'd0);
      chk("rstw_StallM", {31'd0, StallM}, 32'd0);
      MemReadM = 1'b0;
      @(negedge clk);
      chk("rstw_ReadDataM", ReadDataM, 32'd0);
      chk("rstw_addr", bus_addr, 32'd0);
      #1 reset = 1'b0;
    end

    do_access("lhu",  1, 0, 3'b101, 32'h002, 32'h0, 0, 0, 32'hABCD0000, 3, 1, 4'hF, 32'h0,
              32'h0000ABCD, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    do_access("sw_mis", 0, 1, 3'b010, 32'h101, 32'hCAFEF00D, 0, 0, 32'h0, 1, 0, 4'h0, 32'h0,
              32'h0, 0, 1);
    do_access("lh_mis", 1, 0, 3'b001, 32'h101, 32'h0, 0, 0, 32'h12348765, 1, 0, 4'h0, 32'h0,
              32'h0, 0, 1);
`else
    do_access("sw_mis", 0, 1, 3'b010, 32'h101, 32'hCAFEF00D, 0, 0, 32'h0, 2, 1, 4'hF,
              32'hCAFEF00D, 32'h0000ABCD, 0, 0);
    do_access("lh_mis", 1, 0, 3'b001, 32'h101, 32'h0, 0, 0, 32'h12348765, 3, 1, 4'hF, 32'h0,
              32'hFFFF8765, 0, 0);
`endif

    repeat (2) @(posedge clk);
    chk("rsp_q_empty", rsp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
